systolic_setup: RTL and testbench

Input skew stage placed directly upstream of `matrix_multiply_unit`. It accepts one activation row per cycle, all `MATRIX_WIDTH` bytes in parallel, and re-times lane j by j cycles. This produces the diagonal wavefront that the systolic array's `systolic_data` input needs. It also frames each batch: it flushes the skew pipeline with zero rows after the last row, drives the batch sign onto `systolic_signed`, and reports busy/done to the controller.

---
 rtl/systolic_setup_if.sv | 28 ++
 rtl/systolic_setup.sv | 128 ++++++++++++
 tb/tb_systolic_setup.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_setup_if.sv
// Row-in / skewed-row-out bundle between the activation source, systolic_setup and the MMU.
// The master drives rows in and observes the skewed output; the slave is the skew stage.
interface systolic_setup_if #(
    parameter int unsigned MATRIX_WIDTH = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [MATRIX_WIDTH-1:0][7:0] in_data;
    logic                         in_signed;
    logic                         in_last;

    logic [MATRIX_WIDTH-1:0][7:0] systolic_data;
    logic                         systolic_signed;
    logic [MATRIX_WIDTH-1:0]      lane_valid;
    logic                         first_row;
    logic                         busy;
    logic                         done;

    modport master (
        output in_valid, in_data, in_signed, in_last,
        input  in_ready, systolic_data, systolic_signed, lane_valid, first_row, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_last,
        output in_ready, systolic_data, systolic_signed, lane_valid, first_row, busy, done
    );
endinterface

// File: rtl/systolic_setup.sv
// Input skew stage for the systolic array: delays lane j by j cycles to form the diagonal
// wavefront, frames each batch with a zero flush, and reports busy/done.
module systolic_setup #(
    parameter int unsigned MATRIX_WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             enable,
    systolic_setup_if.slave bus
);
    localparam int unsigned CntW = $clog2(MATRIX_WIDTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFeed  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [CntW-1:0]              drain_cnt_q, drain_cnt_d;
    logic                         sign_q, sign_d;
    logic                         done_q, done_d;

    logic [MATRIX_WIDTH-1:0][7:0] row_q;
    logic                         row_vld_q;
    logic                         tag_q;
    logic                         first_q;

    logic [MATRIX_WIDTH-1:0][7:0] lane_data;
    logic [MATRIX_WIDTH-1:0]      lane_vld;

    logic                         in_ready;
    logic                         accept;
    logic                         last_drain;

    // rst is folded in so in_ready reads low while reset is held, whatever enable does.
    assign in_ready   = enable && rst && (state_q == StIdle || state_q == StFeed);
    assign accept     = bus.in_valid && in_ready;
    assign last_drain = (drain_cnt_q == CntW'(MATRIX_WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        sign_d      = sign_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sign_d  = bus.in_signed;
                    state_d = bus.in_last ? StDrain : StFeed;
                end
            end
            StFeed: begin
                if (accept && bus.in_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_drain) begin
                    done_d      = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            sign_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            sign_q      <= sign_d;
            done_q      <= done_d;
        end
    end

    // Input register: non-accepted cycles load a zero bubble so the diagonal stays aligned.
    // The first-row tag rides alongside lane 0 only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q     <= '0;
            row_vld_q <= 1'b0;
            tag_q     <= 1'b0;
            first_q   <= 1'b0;
        end else if (enable) begin
            row_q     <= accept ? bus.in_data : '0;
            row_vld_q <= accept;
            tag_q     <= accept && (state_q == StIdle);
            first_q   <= tag_q;
        end
    end

    for (genvar j = 0; j < MATRIX_WIDTH; j++) begin : g_lane
        logic [j:0][7:0] data_q;
        logic [j:0]      vld_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q <= '0;
                vld_q  <= '0;
            end else if (enable) begin
                data_q[0] <= row_q[j];
                vld_q[0]  <= row_vld_q;
                for (int k = 1; k <= j; k++) begin
                    data_q[k] <= data_q[k-1];
                    vld_q[k]  <= vld_q[k-1];
                end
            end
        end

        assign lane_data[j] = data_q[j];
        assign lane_vld[j]  = vld_q[j];
    end

    assign bus.in_ready        = in_ready;
    assign bus.systolic_data   = lane_data;
    assign bus.lane_valid      = lane_vld;
    assign bus.systolic_signed = sign_q && (|lane_vld);
    assign bus.first_row       = first_q;
    assign bus.busy            = (state_q != StIdle);
    assign bus.done            = done_q;
endmodule

// File: tb/tb_systolic_setup.sv
// Bench for systolic_setup: a hand-computed vector table for the reference batch plus
// model-checked sequences for sign, bubbles, single-row, enable stalls and mid-batch reset.
module tb_systolic_setup;
    localparam int unsigned W = 4;

    typedef logic [W-1:0][7:0] row_t;

    typedef struct {
        logic         en;
        logic         vld;
        row_t         data;
        logic         sgn;
        logic         last;
        row_t         e_data;
        logic [W-1:0] e_vld;
        logic         e_sgn;
        logic         e_first;
        logic         e_busy;
        logic         e_done;
        logic         e_ready;
    } vec_t;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic enable = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vec_t tbl[9];

    row_t seq_row[32];
    logic seq_en[32];
    logic seq_vld[32];
    logic seq_sgn[32];
    logic seq_last[32];

    systolic_setup_if #(.MATRIX_WIDTH(W)) bus ();

    systolic_setup #(.MATRIX_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(int a, int b, int c, int d);
        row_t r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(d);
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(string tag, row_t d, logic [W-1:0] v, logic s, logic f,
                              logic b, logic dn, logic r);
        chk({tag, " data"}, 64'(bus.systolic_data), 64'(d));
        chk({tag, " lane_valid"}, 64'(bus.lane_valid), 64'(v));
        chk({tag, " systolic_signed"}, 64'(bus.systolic_signed), 64'(s));
        chk({tag, " first_row"}, 64'(bus.first_row), 64'(f));
        chk({tag, " busy"}, 64'(bus.busy), 64'(b));
        chk({tag, " done"}, 64'(bus.done), 64'(dn));
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(r));
    endtask

    task automatic apply(logic en, logic vld, row_t data, logic sgn, logic last);
        enable        = en;
        bus.in_valid  = vld;
        bus.in_data   = data;
        bus.in_signed = sgn;
        bus.in_last   = last;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(string name);
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].en, tbl[i].vld, tbl[i].data, tbl[i].sgn, tbl[i].last);
            check_outs($sformatf("%s vec %0d", name, i), tbl[i].e_data, tbl[i].e_vld,
                       tbl[i].e_sgn, tbl[i].e_first, tbl[i].e_busy, tbl[i].e_done,
                       tbl[i].e_ready);
        end
    endtask

    task automatic set_step(int k, logic en, logic vld, row_t row, logic sgn, logic last);
        seq_en[k]   = en;
        seq_vld[k]  = vld;
        seq_row[k]  = row;
        seq_sgn[k]  = sgn;
        seq_last[k] = last;
    endtask

    // Model: every enabled edge appends one slot (row or zero bubble); lane j shows slot
    // eff-2-j. Drain lasts W edges after the last accept; done marks its final edge.
    task automatic run_seq(string name, int n);
        row_t         slot_row[32];
        logic         slot_vld[32];
        int           eff      = 0;
        int           last_eff = -1;
        int           done_eff = 1000;
        logic         bsign    = 1'b0;
        row_t         e_data;
        logic [W-1:0] e_vld;
        logic         e_ready;
        int           s;
        for (int k = 0; k < n; k++) begin
            apply(seq_en[k], seq_vld[k], seq_row[k], seq_sgn[k], seq_last[k]);
            if (seq_en[k]) begin
                slot_row[eff] = seq_vld[k] ? seq_row[k] : '0;
                slot_vld[eff] = seq_vld[k];
                if (seq_vld[k]) begin
                    if (eff == 0) bsign = seq_sgn[k];
                    if (seq_last[k]) begin
                        last_eff = eff + 1;
                        done_eff = last_eff + W;
                    end
                end
                eff++;
            end
            e_data = '0;
            e_vld  = '0;
            for (int j = 0; j < W; j++) begin
                s = eff - 2 - j;
                if (s >= 0 && slot_vld[s]) begin
                    e_data[j] = slot_row[s][j];
                    e_vld[j]  = 1'b1;
                end
            end
            e_ready = seq_en[k] && !(last_eff > 0 && eff >= last_eff && eff < done_eff);
            check_outs($sformatf("%s step %0d", name, k), e_data, e_vld, bsign && (e_vld != '0),
                       eff == 2, eff >= 1 && eff < done_eff, eff == done_eff, e_ready);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.in_last   = 1'b0;
        enable        = 1'b1;

        tbl[0] = '{1'b1, 1'b1, mk(40, 76, 19, 192), 1'b0, 1'b0, mk(0, 0, 0, 0), 4'b0000,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, mk(3, 84, 12, 8), 1'b0, 1'b0, mk(40, 0, 0, 0), 4'b0001,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, mk(54, 18, 255, 120), 1'b0, 1'b0, mk(3, 76, 0, 0), 4'b0011,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, mk(30, 84, 122, 2), 1'b0, 1'b1, mk(54, 84, 19, 0), 4'b0111,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, mk(30, 18, 12, 192), 4'b1111,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, mk(0, 84, 255, 8), 4'b1110,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, mk(0, 0, 122, 120), 4'b1100,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, mk(0, 0, 0, 2), 4'b1000,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, mk(0, 0, 0, 0), 4'b0000,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state, with enable already high: in_ready must still read low.
        #3;
        check_outs("reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #9;
        rst = 1'b1;

        run_table("unsigned");

        // Signed batch; in_signed drops on row 2 and must be ignored.
        set_step(0, 1'b1, 1'b1, mk(74, 91, 64, 10), 1'b1, 1'b0);
        set_step(1, 1'b1, 1'b1, mk(5, 6, 7, 8), 1'b1, 1'b0);
        set_step(2, 1'b1, 1'b1, mk(9, 10, 11, 12), 1'b0, 1'b0);
        set_step(3, 1'b1, 1'b1, mk(13, 14, 15, 16), 1'b0, 1'b1);
        for (int k = 4; k < 9; k++) set_step(k, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        run_seq("signed", 9);

        // Two-cycle bubble between rows 1 and 2.
        set_step(0, 1'b1, 1'b1, mk(40, 76, 19, 192), 1'b0, 1'b0);
        set_step(1, 1'b1, 1'b1, mk(3, 84, 12, 8), 1'b0, 1'b0);
        set_step(2, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        set_step(3, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        set_step(4, 1'b1, 1'b1, mk(54, 18, 255, 120), 1'b0, 1'b0);
        set_step(5, 1'b1, 1'b1, mk(30, 84, 122, 2), 1'b0, 1'b1);
        for (int k = 6; k < 11; k++) set_step(k, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        run_seq("bubble", 11);

        // Single-row batch goes straight to drain.
        set_step(0, 1'b1, 1'b1, mk(1, 2, 3, 4), 1'b1, 1'b1);
        for (int k = 1; k < 6; k++) set_step(k, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        run_seq("single", 6);

        // enable low for three cycles in the middle of drain.
        set_step(0, 1'b1, 1'b1, mk(1, 2, 3, 4), 1'b0, 1'b1);
        set_step(1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        set_step(2, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 3; k < 6; k++) set_step(k, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 6; k < 9; k++) set_step(k, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        run_seq("stall", 9);

        // Asynchronous reset during FEED after two rows.
        apply(1'b1, 1'b1, mk(40, 76, 19, 192), 1'b0, 1'b0);
        apply(1'b1, 1'b1, mk(3, 84, 12, 8), 1'b0, 1'b0);
        chk("pre-reset lane0", 64'(bus.systolic_data[0]), 64'd40);
        rst = 1'b0;
        #1;
        check_outs("mid reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        run_table("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
